// File: rtl/sdram_ctrl_if.sv
// sdram_ctrl_if -- host request/response bundle for sdram_ctrl.
//   req_valid / req_ready : request handshake (accept when both high at clk edge)
//   req_we                : 1 = write, 0 = read
//   req_addr              : {bank[1:0], row, col}
//   req_wdata             : write data
//   rsp_valid             : one-cycle completion pulse (reads and writes)
//   rsp_rdata             : read data, meaningful while rsp_valid on a read
// master = host side, slave = controller side.
interface sdram_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 21
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sdram_ctrl.sv
// sdram_ctrl -- single-request SDRAM command sequencer.
//   Accepts one host request at a time, issues ACTIVATE (bank,row), then
//   READ or WRITE (bank,col), then NOPs while the access completes, and
//   pulses rsp_valid (with rsp_rdata on reads) once done.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   host (slave)      : request/response handshake, see sdram_ctrl_if
//   cs_n/ras_n/cas_n/we_n : SDRAM command pins (registered)
//   sdram_addr        : row on ACTIVATE, zero-extended column on READ/WRITE
//   bank_select       : bank for ACTIVATE/READ/WRITE
//   dq_in             : write data toward the SDRAM
//   dq_out            : read data from the SDRAM
// Build option:
//   SDRAM_CTRL_ROW_HIT_EN -- when defined, the bank/row of the last ACTIVATE
//   is remembered and a request hitting it skips the ACTIVATE cycle.
module sdram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_BITS   = 11,
  parameter int COL_BITS   = 8,
  parameter int WR_NOPS    = 3,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_ctrl_if.slave           host,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [ROW_BITS-1:0]   sdram_addr,
  output logic [1:0]            bank_select,
  output logic [DATA_WIDTH-1:0] dq_in,
  input  logic [DATA_WIDTH-1:0] dq_out
);

  localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
  localparam int MAX_N  = (WR_NOPS > RD_LAT) ? WR_NOPS : RD_LAT;
  // The counter only ever holds N-1, so clog2(N) bits are enough.
  localparam int CNT_W  = (MAX_N < 2) ? 1 : $clog2(MAX_N);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_ACTIVATE = 4'b0011;
  localparam logic [3:0] CMD_READ     = 4'b0101;
  localparam logic [3:0] CMD_WRITE    = 4'b0100;
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_DESELECT = 4'b1111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACT  = 3'd1,
    CMD  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  we_reg, we_next;
  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [3:0]            cmd_reg, cmd_next;
  logic [ROW_BITS-1:0]   sdram_addr_reg, sdram_addr_next;
  logic [1:0]            bank_reg, bank_next;
  logic [DATA_WIDTH-1:0] dq_in_reg, dq_in_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;

`ifdef SDRAM_CTRL_ROW_HIT_EN
  logic                  open_valid_reg, open_valid_next;
  logic [1:0]            open_bank_reg, open_bank_next;
  logic [ROW_BITS-1:0]   open_row_reg, open_row_next;
`endif

  logic                  accept;
  logic                  cur_we;
  logic [ADDR_W-1:0]     cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [1:0]            cur_bank;
  logic [ROW_BITS-1:0]   cur_row;
  logic [COL_BITS-1:0]   cur_col;

  assign host.req_ready = (state_reg == IDLE) && !rst;
  assign accept         = host.req_valid && host.req_ready;

  // Pins are registered from the next state, so the request fields must come
  // straight from the host on the accept edge and from the capture registers
  // afterwards.
  always_comb begin
    if (state_reg == IDLE) begin
      cur_we    = host.req_we;
      cur_addr  = host.req_addr;
      cur_wdata = host.req_wdata;
    end else begin
      cur_we    = we_reg;
      cur_addr  = addr_reg;
      cur_wdata = wdata_reg;
    end
  end

  assign cur_bank = cur_addr[ADDR_W-1 -: 2];
  assign cur_row  = cur_addr[COL_BITS +: ROW_BITS];
  assign cur_col  = cur_addr[COL_BITS-1:0];

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    cmd_next        = CMD_DESELECT;
    sdram_addr_next = sdram_addr_reg;
    bank_next       = bank_reg;
    dq_in_next      = dq_in_reg;
    rsp_valid_next  = 1'b0;
    rsp_rdata_next  = rsp_rdata_reg;
`ifdef SDRAM_CTRL_ROW_HIT_EN
    open_valid_next = open_valid_reg;
    open_bank_next  = open_bank_reg;
    open_row_next   = open_row_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          we_next    = host.req_we;
          addr_next  = host.req_addr;
          wdata_next = host.req_wdata;
`ifdef SDRAM_CTRL_ROW_HIT_EN
          if (open_valid_reg && (open_bank_reg == cur_bank) &&
              (open_row_reg == cur_row)) begin
            state_next = CMD;
          end else begin
            state_next = ACT;
          end
`else
          state_next = ACT;
`endif
        end
      end
      ACT:  state_next = CMD;
      CMD: begin
        state_next = WAIT;
        cnt_next   = we_reg ? CNT_W'(WR_NOPS - 1) : CNT_W'(RD_LAT - 1);
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Registered outputs for the cycle the FSM is about to enter.
    case (state_next)
      ACT: begin
        cmd_next        = CMD_ACTIVATE;
        sdram_addr_next = cur_row;
        bank_next       = cur_bank;
`ifdef SDRAM_CTRL_ROW_HIT_EN
        open_valid_next = 1'b1;
        open_bank_next  = cur_bank;
        open_row_next   = cur_row;
`endif
      end
      CMD: begin
        cmd_next        = cur_we ? CMD_WRITE : CMD_READ;
        sdram_addr_next = ROW_BITS'(cur_col);
        bank_next       = cur_bank;
        if (cur_we) begin
          dq_in_next = cur_wdata;
        end
      end
      WAIT: cmd_next = CMD_NOP;
      RESP: begin
        rsp_valid_next = 1'b1;
        // dq_out is sampled on the edge that ends the last NOP.
        if (!we_reg) begin
          rsp_rdata_next = dq_out;
        end
      end
      default: cmd_next = CMD_DESELECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cmd_reg        <= CMD_DESELECT;
      sdram_addr_reg <= '0;
      bank_reg       <= '0;
      dq_in_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
`ifdef SDRAM_CTRL_ROW_HIT_EN
      open_valid_reg <= 1'b0;
      open_bank_reg  <= '0;
      open_row_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      cmd_reg        <= cmd_next;
      sdram_addr_reg <= sdram_addr_next;
      bank_reg       <= bank_next;
      dq_in_reg      <= dq_in_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
`ifdef SDRAM_CTRL_ROW_HIT_EN
      open_valid_reg <= open_valid_next;
      open_bank_reg  <= open_bank_next;
      open_row_reg   <= open_row_next;
`endif
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_reg;
  assign sdram_addr     = sdram_addr_reg;
  assign bank_select    = bank_reg;
  assign dq_in          = dq_in_reg;
  assign host.rsp_valid = rsp_valid_reg;
  assign host.rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl -- self-checking bench for sdram_ctrl.
// A behavioural SDRAM model answers READ after RD_LAT cycles; directed
// vectors are checked cycle by cycle against hand-derived pin sequences.
module tb_sdram_ctrl;
  localparam int DW = 16;
  localparam int RB = 11;
  localparam int CB = 8;
  localparam int WN = 3;
  localparam int RL = 2;
  localparam int AW = 2 + RB + CB;

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_DES = 4'b1111;

`ifdef SDRAM_CTRL_ROW_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n, ras_n, cas_n, we_n;
  logic [RB-1:0] sdram_addr;
  logic [1:0]    bank_select;
  logic [DW-1:0] dq_in;
  logic [DW-1:0] dq_out;

  sdram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) host ();

  sdram_ctrl #(
    .DATA_WIDTH(DW), .ROW_BITS(RB), .COL_BITS(CB), .WR_NOPS(WN), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .host(host),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .sdram_addr(sdram_addr), .bank_select(bank_select),
    .dq_in(dq_in), .dq_out(dq_out)
  );

  always #5 clk = ~clk;

  // ---------------- SDRAM behavioural model ----------------
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [RB-1:0] mrow [0:3];
  logic          rd_v [0:RL-2];
  logic [AW-1:0] rd_a [0:RL-2];
  logic [3:0]    pins;
  assign pins = {cs_n, ras_n, cas_n, we_n};

  initial dq_out = 16'hDEAD;

  always @(posedge clk) begin
    if (pins == C_ACT) mrow[bank_select] <= sdram_addr;
    if (pins == C_WR)
      mem[{bank_select, mrow[bank_select], sdram_addr[CB-1:0]}] <= dq_in;
    rd_v[0] <= (pins == C_RD);
    rd_a[0] <= {bank_select, mrow[bank_select], sdram_addr[CB-1:0]};
    for (int i = 1; i < RL - 1; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
    dq_out <= rd_v[RL-2] ? mem[rd_a[RL-2]] : 16'hDEAD;
  end

  int rsp_pulses = 0;
  always @(posedge clk) if (host.rsp_valid) rsp_pulses <= rsp_pulses + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic          m_open_valid = 1'b0;
  logic [1:0]    m_open_bank  = '0;
  logic [RB-1:0] m_open_row   = '0;
  logic [DW-1:0] last_rdata   = '0;
  logic [DW-1:0] last_wdata   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [1:0] bank,
                         input logic [RB-1:0] row, input logic [CB-1:0] col,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                         input bit keep_valid);
    bit hit;
    int first_cmd, lat, waited;
    logic [3:0] exp_cmd;
    @(negedge clk);
    waited = 0;
    while (!host.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("%s.ready", tag), 32'(host.req_ready), 32'd1);
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_addr  = {bank, row, col};
    host.req_wdata = wdata;
    hit = HIT_EN && m_open_valid && (m_open_bank == bank) && (m_open_row == row);
    if (!hit) begin
      m_open_valid = 1'b1;
      m_open_bank  = bank;
      m_open_row   = row;
    end
    first_cmd = hit ? 1 : 2;
    lat = first_cmd + 1 + (we ? WN : RL);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_valid) host.req_valid = 1'b0;
      if (k < first_cmd)       exp_cmd = C_ACT;
      else if (k == first_cmd) exp_cmd = we ? C_WR : C_RD;
      else if (k < lat)        exp_cmd = C_NOP;
      else                     exp_cmd = C_DES;
      check($sformatf("%s.cmd@T+%0d", tag, k), 32'(pins), 32'(exp_cmd));
      check($sformatf("%s.rsp_valid@T+%0d", tag, k), 32'(host.rsp_valid), 32'(k == lat));
      check($sformatf("%s.ready@T+%0d", tag, k), 32'(host.req_ready), 32'd0);
      if (k == 1 && !hit) begin
        check($sformatf("%s.act_bank", tag), 32'(bank_select), 32'(bank));
        check($sformatf("%s.act_row", tag), 32'(sdram_addr), 32'(row));
      end
      if (k == first_cmd) begin
        check($sformatf("%s.cmd_bank", tag), 32'(bank_select), 32'(bank));
        check($sformatf("%s.cmd_col", tag), 32'(sdram_addr), 32'(col));
        if (we) begin
          check($sformatf("%s.dq_in", tag), 32'(dq_in), 32'(wdata));
          last_wdata = wdata;
        end
      end
      if (k == lat) begin
        if (!we) last_rdata = exp_rdata;
        check($sformatf("%s.rdata", tag), 32'(host.rsp_rdata), 32'(last_rdata));
        check($sformatf("%s.dq_hold", tag), 32'(dq_in), 32'(last_wdata));
      end
    end
    $display("txn %s we=%0d bank=%0d row=%0d col=%0d wdata=%h rdata=%h hit=%0d lat=%0d",
             tag, we, bank, row, col, wdata, host.rsp_rdata, hit, lat);
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    bank;
    logic [RB-1:0] row;
    logic [CB-1:0] col;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  int   p0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd1, 11'd5,    8'd9,   16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 2'd1, 11'd5,    8'd9,   16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 2'd0, 11'd0,    8'd0,   16'h1111, 16'h0000};
    vecs[3] = '{1'b1, 2'd3, 11'd2047, 8'd255, 16'h2222, 16'h0000};
    vecs[4] = '{1'b0, 2'd0, 11'd0,    8'd0,   16'h0000, 16'h1111};
    vecs[5] = '{1'b0, 2'd3, 11'd2047, 8'd255, 16'h0000, 16'h2222};
    vecs[6] = '{1'b1, 2'd2, 11'd100,  8'd3,   16'hA5A5, 16'h0000};
    vecs[7] = '{1'b0, 2'd2, 11'd100,  8'd3,   16'h0000, 16'hA5A5};

    host.req_valid = 1'b0;
    host.req_we    = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.pins",      32'(pins), 32'(C_DES));
    check("rst.addr",      32'(sdram_addr), 32'd0);
    check("rst.bank",      32'(bank_select), 32'd0);
    check("rst.dq_in",     32'(dq_in), 32'd0);
    check("rst.rsp_valid", 32'(host.rsp_valid), 32'd0);
    check("rst.rsp_rdata", 32'(host.rsp_rdata), 32'd0);
    check("rst.ready",     32'(host.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(host.req_ready), 32'd1);

    // Table-driven transactions.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].we, vecs[i].bank, vecs[i].row,
              vecs[i].col, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
    end

    // req_valid held high across four back-to-back transactions.
    @(negedge clk);
    p0 = rsp_pulses;
    run_txn("b0", 1'b1, 2'd0, 11'd7, 8'd1, 16'h0A0A, 16'h0000, 1'b1);
    run_txn("b1", 1'b1, 2'd0, 11'd7, 8'd2, 16'h0B0B, 16'h0000, 1'b1);
    run_txn("b2", 1'b0, 2'd0, 11'd7, 8'd1, 16'h0000, 16'h0A0A, 1'b1);
    run_txn("b3", 1'b0, 2'd0, 11'd7, 8'd2, 16'h0000, 16'h0B0B, 1'b1);
    host.req_valid = 1'b0;
    @(negedge clk);
    check("b.pulses", 32'(rsp_pulses - p0), 32'd4);

    // Reset asserted during the WAIT phase of a read.
    @(negedge clk);
    host.req_valid = 1'b1;
    host.req_we    = 1'b0;
    host.req_addr  = {2'd2, 11'd100, 8'd3};
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) host.req_valid = 1'b0;
    end
    check("abort.wait_nop", 32'(pins), 32'(C_NOP));
    p0 = rsp_pulses;
    rst = 1'b1;
    #1;
    check("abort.pins",  32'(pins), 32'(C_DES));
    check("abort.ready", 32'(host.req_ready), 32'd0);
    check("abort.rsp",   32'(host.rsp_valid), 32'd0);
    @(negedge clk);
    check("abort.ready_hold", 32'(host.req_ready), 32'd0);
    rst = 1'b0;
    m_open_valid = 1'b0;
    last_rdata   = '0;
    last_wdata   = '0;
    #1;
    check("abort.ready_release", 32'(host.req_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("abort.no_pulse", 32'(rsp_pulses - p0), 32'd0);
    check("abort.rdata_cleared", 32'(host.rsp_rdata), 32'd0);

    // The row record is cleared by reset, so this read activates again.
    run_txn("post", 1'b0, 2'd1, 11'd5, 8'd9, 16'h0000, 16'hBEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
